// File: rtl/mem_access_ctrl.sv
// Single-outstanding bus master: queues core load/store requests and runs the memory request/response handshake with a timeout.
// Latency: request accepted at posedge N issues at N+1, completes (rsp_valid) in the cycle after N+2, next issue no earlier than N+4.
// Backpressure: cpu_ready drops when the request FIFO is full; memory is never re-requested while its response is still high.

// Generic synchronous FIFO: head word visible combinationally, count exported for the ready calculation.
// Latency: a pushed word is visible at the head one cycle after the push edge; no bypass.
// Backpressure: pushes while full and pops while empty are ignored.
module mem_access_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];
  assign w_push     = i_push && !w_full;
  assign w_pop      = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end
endmodule

module mem_access_ctrl #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 8,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_valid,
  output logic              o_cpu_ready,
  input  logic              i_cpu_write,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_rsp_valid,
  output logic              o_rsp_write,
  output logic              o_rsp_err,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_busy,
  output logic              o_mem_request,
  output logic              o_mem_mode_flag,
  output logic [ADDR_W-1:0] o_mem_locator,
  output logic [DATA_W-1:0] o_mem_write_bus,
  input  logic [DATA_W-1:0] i_mem_read_bus,
  input  logic              i_mem_response
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_RELEASE
  } state_t;

  state_t            r_state;
  logic [TMR_W-1:0]  r_timer;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_mem_request;
  logic              r_mem_mode_flag;
  logic [ADDR_W-1:0] r_mem_locator;
  logic [DATA_W-1:0] r_mem_write_bus;

  req_t              w_push_req;
  req_t              w_head_req;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_push;
  logic              w_issue;

  assign w_push_req = '{write: i_cpu_write, addr: i_cpu_addr, wdata: i_cpu_wdata};
  assign o_cpu_ready = (w_count < CNT_W'(DEPTH));
  assign w_push      = i_cpu_valid && o_cpu_ready;
  // A response still high from a previous access (or left over after reset) holds off the next issue.
  assign w_issue     = (r_state == ST_IDLE) && !w_empty && !i_mem_response;
  assign o_busy      = !w_empty || (r_state != ST_IDLE);

  mem_access_ctrl_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_push),
    .i_push_dat (w_push_req),
    .i_pop      (w_issue),
    .o_head_dat (w_head_req),
    .o_count    (w_count),
    .o_empty    (w_empty)
  );

  // Access sequencer: issue one request, wait for response or timeout, then wait for response release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_timer         <= '0;
      r_rsp_valid     <= 1'b0;
      r_rsp_write     <= 1'b0;
      r_rsp_err       <= 1'b0;
      r_rsp_rdata     <= '0;
      r_mem_request   <= 1'b0;
      r_mem_mode_flag <= 1'b0;
      r_mem_locator   <= '0;
      r_mem_write_bus <= '0;
    end else begin
      // Completion fields are single-cycle pulses.
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_mem_request   <= 1'b1;
            r_mem_mode_flag <= w_head_req.write;
            r_mem_locator   <= w_head_req.addr;
            r_mem_write_bus <= w_head_req.wdata;
            r_timer         <= '0;
            r_state         <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (i_mem_response) begin
            r_mem_request <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= r_mem_mode_flag;
            r_rsp_rdata   <= r_mem_mode_flag ? '0 : i_mem_read_bus;
            r_state       <= ST_RELEASE;
          end else if (r_timer == TMR_LAST) begin
            // Memory never answered: abort so the core is not stalled forever.
            r_mem_request <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_write   <= r_mem_mode_flag;
            r_rsp_err     <= 1'b1;
            r_state       <= ST_RELEASE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_RELEASE: begin
          if (!i_mem_response) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_write     = r_rsp_write;
  assign o_rsp_err       = r_rsp_err;
  assign o_rsp_rdata     = r_rsp_rdata;
  assign o_mem_request   = r_mem_request;
  assign o_mem_mode_flag = r_mem_mode_flag;
  assign o_mem_locator   = r_mem_locator;
  assign o_mem_write_bus = r_mem_write_bus;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a negedge memory model and a posedge+2 monitor.
// Latency: expectations are cycle numbers relative to the CPU accept edge.
// Backpressure: exercised through FIFO fill, held response and silent memory.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic        cpu_write = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        rsp_valid, rsp_write, rsp_err;
  logic [15:0] rsp_rdata;
  logic        busy;
  logic        mem_request, mem_mode_flag;
  logic [15:0] mem_locator, mem_write_bus;
  logic [15:0] mem_read_bus = '0;
  logic        mem_response = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_valid(cpu_valid), .o_cpu_ready(cpu_ready), .i_cpu_write(cpu_write),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_write(rsp_write), .o_rsp_err(rsp_err), .o_rsp_rdata(rsp_rdata),
    .o_busy(busy), .o_mem_request(mem_request), .o_mem_mode_flag(mem_mode_flag),
    .o_mem_locator(mem_locator), .o_mem_write_bus(mem_write_bus),
    .i_mem_read_bus(mem_read_bus), .i_mem_response(mem_response)
  );

  // Memory model: acts on negedge, answers the first negedge of a request.
  logic [15:0] mem [logic [15:0]];
  logic mute = 1'b0;
  logic force_resp = 1'b0;
  always @(negedge clk) begin
    if (force_resp) mem_response <= 1'b1;
    else if (mem_request && !mem_response && !mute) begin
      if (mem_mode_flag) mem[mem_locator] = mem_write_bus;
      else mem_read_bus <= mem.exists(mem_locator) ? mem[mem_locator] : 16'h0000;
      mem_response <= 1'b1;
    end else if (!mem_request) mem_response <= 1'b0;
  end

  // Monitor: logs issues, request falls and completions; tracks request-field stability.
  typedef struct { int cyc; logic mode; logic [15:0] loc; logic [15:0] dat; } iss_t;
  typedef struct { int cyc; logic wr; logic err; logic [15:0] rdata; } rsp_t;
  iss_t issue_q[$];
  rsp_t rsp_q[$];
  int   fall_q[$];
  int   stab_err = 0;
  logic prev_req = 1'b0;
  iss_t hold;
  always @(posedge clk) begin
    iss_t ie;
    rsp_t re;
    #2;
    if (mem_request && !prev_req) begin
      ie.cyc = cyc; ie.mode = mem_mode_flag; ie.loc = mem_locator; ie.dat = mem_write_bus;
      issue_q.push_back(ie);
      hold = ie;
    end
    if (mem_request && prev_req &&
        (mem_mode_flag !== hold.mode || mem_locator !== hold.loc || mem_write_bus !== hold.dat))
      stab_err++;
    if (!mem_request && prev_req) fall_q.push_back(cyc);
    if (rsp_valid) begin
      re.cyc = cyc; re.wr = rsp_write; re.err = rsp_err; re.rdata = rsp_rdata;
      rsp_q.push_back(re);
    end
    prev_req = mem_request;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge after the accepting posedge, valid still high.
  task automatic push_req(input logic w, input logic [15:0] a, input logic [15:0] d, output int acc);
    int g = 0;
    cpu_valid = 1'b1; cpu_write = w; cpu_addr = a; cpu_wdata = d;
    while (!cpu_ready && g < 50) begin @(negedge clk); g++; end
    chk("push_ready", {31'd0, cpu_ready}, 32'd1);
    @(negedge clk);
    acc = cyc;
  endtask

  task automatic wait_done(input int n);
    int g = 0;
    cpu_valid = 1'b0;
    do begin @(negedge clk); g++; end while (!(rsp_q.size() >= n && !busy) && g < 200);
    chk("done_count", rsp_q.size(), n);
  endtask

  task automatic clear_logs();
    issue_q.delete(); rsp_q.delete(); fall_q.delete();
  endtask

  initial begin
    int a0, a1, a2, m;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, m, acc[8];
    // Reset state
    @(negedge clk);
    chk("rst_ready", {31'd0, cpu_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req", {31'd0, mem_request}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: store 0x0010=BEEF then load 0x0010
    push_req(1'b1, 16'h0010, 16'hBEEF, a0);
    push_req(1'b0, 16'h0010, 16'h0000, a1);
    wait_done(2);
    chk("t1_acc1", a1, a0 + 1);
    chk("t1_iss0_cyc", issue_q[0].cyc, a0 + 1);
    chk("t1_iss0_mode", {31'd0, issue_q[0].mode}, 32'd1);
    chk("t1_iss0_loc", {16'd0, issue_q[0].loc}, 32'h0010);
    chk("t1_iss0_dat", {16'd0, issue_q[0].dat}, 32'hBEEF);
    chk("t1_rsp0_cyc", rsp_q[0].cyc, a0 + 2);
    chk("t1_rsp0_wr", {31'd0, rsp_q[0].wr}, 32'd1);
    chk("t1_rsp0_rdata", {16'd0, rsp_q[0].rdata}, 32'd0);
    chk("t1_iss1_cyc", issue_q[1].cyc, a0 + 4);
    chk("t1_iss1_mode", {31'd0, issue_q[1].mode}, 32'd0);
    chk("t1_rsp1_cyc", rsp_q[1].cyc, a0 + 5);
    chk("t1_rsp1_wr", {31'd0, rsp_q[1].wr}, 32'd0);
    chk("t1_rsp1_err", {31'd0, rsp_q[1].err}, 32'd0);
    chk("t1_rsp1_rdata", {16'd0, rsp_q[1].rdata}, 32'hBEEF);
    clear_logs();

    // 2: three back-to-back stores to 1,2,3
    push_req(1'b1, 16'h0001, 16'h1111, a0);
    push_req(1'b1, 16'h0002, 16'h2222, a1);
    push_req(1'b1, 16'h0003, 16'h3333, a2);
    chk("t2_ready_full", {31'd0, cpu_ready}, 32'd0);
    chk("t2_acc2", a2, a0 + 2);
    wait_done(3);
    chk("t2_iss_n", issue_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      chk("t2_iss_cyc", issue_q[k].cyc, a0 + 1 + 3 * k);
      chk("t2_iss_loc", {16'd0, issue_q[k].loc}, k + 1);
      chk("t2_rsp_cyc", rsp_q[k].cyc, a0 + 2 + 3 * k);
    end
    clear_logs();

    // 3: memory never responds -> timeout abort
    @(posedge clk); #1 mute = 1'b1;
    @(negedge clk);
    push_req(1'b0, 16'h0020, 16'h0000, a0);
    wait_done(1);
    chk("t3_iss_cyc", issue_q[0].cyc, a0 + 1);
    chk("t3_fall_cyc", fall_q[0], a0 + 9);
    chk("t3_rsp_cyc", rsp_q[0].cyc, a0 + 9);
    chk("t3_rsp_err", {31'd0, rsp_q[0].err}, 32'd1);
    chk("t3_rsp_rdata", {16'd0, rsp_q[0].rdata}, 32'd0);
    chk("t3_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1 mute = 1'b0;
    @(negedge clk);
    clear_logs();

    // 4: response held high blocks issue
    @(posedge clk); #1 force_resp = 1'b1;
    repeat (2) @(negedge clk);
    push_req(1'b1, 16'h0030, 16'hCAFE, a0);
    push_req(1'b1, 16'h0031, 16'h0D0D, a1);
    cpu_valid = 1'b0;
    chk("t4_ready_full", {31'd0, cpu_ready}, 32'd0);
    repeat (3) @(negedge clk);
    chk("t4_no_req", {31'd0, mem_request}, 32'd0);
    chk("t4_no_issue", issue_q.size(), 0);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    m = cyc;
    @(posedge clk); #1 force_resp = 1'b0;
    wait_done(2);
    chk("t4_iss0_cyc", issue_q[0].cyc, m + 2);
    chk("t4_rsp0_cyc", rsp_q[0].cyc, m + 3);
    chk("t4_iss1_cyc", issue_q[1].cyc, m + 5);
    chk("t4_iss1_loc", {16'd0, issue_q[1].loc}, 32'h0031);
    clear_logs();

    // 5: reset while waiting for an ack
    @(posedge clk); #1 mute = 1'b1;
    @(negedge clk);
    push_req(1'b1, 16'h0040, 16'h5555, a0);
    push_req(1'b0, 16'h0030, 16'h0000, a1);
    cpu_valid = 1'b0;
    @(negedge clk);
    chk("t5_req_before", {31'd0, mem_request}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_req_rst", {31'd0, mem_request}, 32'd0);
    chk("t5_ready_rst", {31'd0, cpu_ready}, 32'd1);
    chk("t5_busy_rst", {31'd0, busy}, 32'd0);
    chk("t5_rspv_rst", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1 mute = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_no_rsp", rsp_q.size(), 0);
    chk("t5_idle_busy", {31'd0, busy}, 32'd0);
    clear_logs();
    push_req(1'b0, 16'h0030, 16'h0000, a0);
    push_req(1'b0, 16'h0040, 16'h0000, a1);
    wait_done(2);
    chk("t5_load30", {16'd0, rsp_q[0].rdata}, 32'hCAFE);
    chk("t5_load40", {16'd0, rsp_q[1].rdata}, 32'h0000);
    clear_logs();

    // 6: pointer wrap, store 0..7 then load 0..7
    for (int k = 0; k < 8; k++) push_req(1'b1, 16'(k), 16'hA000 + 16'(k), acc[k]);
    wait_done(8);
    clear_logs();
    for (int k = 0; k < 8; k++) begin
      push_req(1'b0, 16'(k), 16'h0000, acc[k]);
      if (k == 1) chk("t6_ready_pushpop", {31'd0, cpu_ready}, 32'd1);
      if (k == 2) chk("t6_ready_full", {31'd0, cpu_ready}, 32'd0);
    end
    wait_done(8);
    chk("t6_acc1", acc[1], acc[0] + 1);
    for (int k = 0; k < 8; k++) begin
      chk("t6_rdata", {16'd0, rsp_q[k].rdata}, 32'hA000 + k);
      chk("t6_spacing", rsp_q[k].cyc - rsp_q[0].cyc, 3 * k);
    end
    chk("t6_issue_n", issue_q.size(), 8);
    chk("stability", stab_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
